// File: rtl/fastica_pkg.sv
// fastica_pkg: widths, saturation bounds, Gram entry schedule and FSM states
// shared by the symm_gram stage and its MAC unit.
package fastica_pkg;

    localparam int DW     = 26;          // matrix element width
    localparam int FRAC   = 20;          // Q5.20, 1.0 = 1048576
    localparam int PROD_W = 2*DW;        // full signed product
    localparam int ACC_W  = 2*DW + 2;    // 4-term sum never overflows
    localparam int N_ENT  = 10;          // unique entries of a symmetric 4x4

    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_BIAS = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    // Upper-triangle visiting order (0-based row/col)
    localparam logic [1:0] SCHED_ROW [N_ENT] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    localparam logic [1:0] SCHED_COL [N_ENT] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gram_mac_unit.sv
// gram_mac_unit: signed multiply, 54-bit accumulate, and floor-shift (or
// round-half-up when SYMM_GRAM_ROUND_EN is defined) with saturation of
// acc+product. o_result is valid in the cycle i_last is high.
module gram_mac_unit
    import fastica_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_acc_en,
    input  logic          i_last,
    input  logic [DW-1:0] i_op_a,
    input  logic [DW-1:0] i_op_b,
    output logic [DW-1:0] o_result
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_biased;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod = $signed(i_op_a) * $signed(i_op_b);
    assign w_sum  = r_acc + $signed({{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod});

`ifdef SYMM_GRAM_ROUND_EN
    assign w_biased = w_sum + RND_BIAS;
`else
    assign w_biased = w_sum;
`endif

    assign w_shift = w_biased >>> FRAC;

    // Clamp the shifted sum into the DW-bit signed range
    always_comb begin
        o_result = w_shift[DW-1:0];
        if (w_shift > SAT_MAX) begin
            o_result = SAT_MAX[DW-1:0];
        end else if (w_shift < SAT_MIN) begin
            o_result = SAT_MIN[DW-1:0];
        end
    end

    // Accumulator: cleared on start and after the last term of each entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= i_last ? '0 : w_sum;
        end
    end

endmodule

// File: rtl/symm_gram.sv
// symm_gram: G = W*W^T for a 4x4 Q5.20 matrix using one time-shared MAC.
// The 10 unique entries take 4 cycles each; each result is written to both
// mirror positions. Optional macro SYMM_GRAM_ROUND_EN selects round-half-up.
module symm_gram
    import fastica_pkg::*;
(
    input  logic          clk_gram,
    input  logic          rstn_gram,
    input  logic          en_gram,
    input  logic [DW-1:0] w11, w12, w13, w14,
    input  logic [DW-1:0] w21, w22, w23, w24,
    input  logic [DW-1:0] w31, w32, w33, w34,
    input  logic [DW-1:0] w41, w42, w43, w44,
    output logic          busy_gram,
    output logic          done_gram,
    output logic [DW-1:0] g11, g12, g13, g14,
    output logic [DW-1:0] g21, g22, g23, g24,
    output logic [DW-1:0] g31, g32, g33, g34,
    output logic [DW-1:0] g41, g42, g43, g44
);

    logic [DW-1:0] w_win  [4][4];
    logic [DW-1:0] r_bank [4][4];
    logic [DW-1:0] r_g    [4][4];

    state_t        r_state, w_state_nx;
    logic [3:0]    r_e;
    logic [1:0]    r_k;
    logic          w_accept, w_mac, w_last, w_final;
    logic [1:0]    w_row, w_col;
    logic [DW-1:0] w_op_a, w_op_b, w_result;

    assign w_win[0][0] = w11;  assign w_win[0][1] = w12;  assign w_win[0][2] = w13;  assign w_win[0][3] = w14;
    assign w_win[1][0] = w21;  assign w_win[1][1] = w22;  assign w_win[1][2] = w23;  assign w_win[1][3] = w24;
    assign w_win[2][0] = w31;  assign w_win[2][1] = w32;  assign w_win[2][2] = w33;  assign w_win[2][3] = w34;
    assign w_win[3][0] = w41;  assign w_win[3][1] = w42;  assign w_win[3][2] = w43;  assign w_win[3][3] = w44;

    assign g11 = r_g[0][0];  assign g12 = r_g[0][1];  assign g13 = r_g[0][2];  assign g14 = r_g[0][3];
    assign g21 = r_g[1][0];  assign g22 = r_g[1][1];  assign g23 = r_g[1][2];  assign g24 = r_g[1][3];
    assign g31 = r_g[2][0];  assign g32 = r_g[2][1];  assign g33 = r_g[2][2];  assign g34 = r_g[2][3];
    assign g41 = r_g[3][0];  assign g42 = r_g[3][1];  assign g43 = r_g[3][2];  assign g44 = r_g[3][3];

    assign w_row  = SCHED_ROW[r_e];
    assign w_col  = SCHED_COL[r_e];
    assign w_op_a = r_bank[w_row][r_k];
    assign w_op_b = r_bank[w_col][r_k];

    assign busy_gram = (r_state != ST_IDLE);
    assign done_gram = (r_state == ST_DONE);

    // State register
    always_ff @(posedge clk_gram or negedge rstn_gram) begin
        if (!rstn_gram) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and per-cycle control
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_mac      = 1'b0;
        w_last     = 1'b0;
        w_final    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en_gram) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_MAC;
                end
            end
            ST_MAC: begin
                w_mac   = 1'b1;
                w_last  = (r_k == 2'd3);
                w_final = w_last && (r_e == 4'(N_ENT-1));
                if (w_final) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Operand capture, entry/term counters and mirrored result write
    always_ff @(posedge clk_gram or negedge rstn_gram) begin
        if (!rstn_gram) begin
            r_e    <= '0;
            r_k    <= '0;
            r_bank <= '{default: '0};
            r_g    <= '{default: '0};
        end else if (w_accept) begin
            r_e    <= '0;
            r_k    <= '0;
            r_bank <= w_win;
        end else if (w_mac) begin
            r_k <= r_k + 2'd1;
            if (w_last) begin
                r_e                 <= w_final ? 4'd0 : r_e + 4'd1;
                r_g[w_row][w_col]   <= w_result;
                r_g[w_col][w_row]   <= w_result;
            end
        end
    end

    gram_mac_unit u_mac (
        .i_clk    (clk_gram),
        .i_rst_n  (rstn_gram),
        .i_clr    (w_accept),
        .i_acc_en (w_mac),
        .i_last   (w_last),
        .i_op_a   (w_op_a),
        .i_op_b   (w_op_b),
        .o_result (w_result)
    );

endmodule

// File: tb/tb_symm_gram.sv
// tb_symm_gram: scoreboard bench for symm_gram. Expected G matrices are
// pushed when a run is started and popped when done_gram is observed.
module tb_symm_gram;

    typedef logic [16*26-1:0] gvec_t;

    logic        clk_gram;
    logic        rstn_gram;
    logic        en_gram;
    logic [25:0] w_in [4][4];
    logic [25:0] g_o  [16];
    logic        busy_gram;
    logic        done_gram;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    busy_cnt = 0;
    int    done_cnt = 0;
    logic  prev_busy = 1'b0;
    gvec_t sb_q [$];
    int    acc_q [$];

`ifdef SYMM_GRAM_ROUND_EN
    localparam longint RND_G11 = 1;
    localparam longint RND_G12 = 0;
`else
    localparam longint RND_G11 = 0;
    localparam longint RND_G12 = -1;
`endif

    symm_gram dut (
        .clk_gram  (clk_gram),
        .rstn_gram (rstn_gram),
        .en_gram   (en_gram),
        .w11 (w_in[0][0]), .w12 (w_in[0][1]), .w13 (w_in[0][2]), .w14 (w_in[0][3]),
        .w21 (w_in[1][0]), .w22 (w_in[1][1]), .w23 (w_in[1][2]), .w24 (w_in[1][3]),
        .w31 (w_in[2][0]), .w32 (w_in[2][1]), .w33 (w_in[2][2]), .w34 (w_in[2][3]),
        .w41 (w_in[3][0]), .w42 (w_in[3][1]), .w43 (w_in[3][2]), .w44 (w_in[3][3]),
        .busy_gram (busy_gram),
        .done_gram (done_gram),
        .g11 (g_o[0]),  .g12 (g_o[1]),  .g13 (g_o[2]),  .g14 (g_o[3]),
        .g21 (g_o[4]),  .g22 (g_o[5]),  .g23 (g_o[6]),  .g24 (g_o[7]),
        .g31 (g_o[8]),  .g32 (g_o[9]),  .g33 (g_o[10]), .g34 (g_o[11]),
        .g41 (g_o[12]), .g42 (g_o[13]), .g43 (g_o[14]), .g44 (g_o[15])
    );

    initial begin
        clk_gram = 1'b0;
        forever #5 clk_gram = ~clk_gram;
    end

    // Cycle stamp for accept spacing
    always @(posedge clk_gram) cyc++;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference entry: exact 4-term dot product, shift (optionally rounded), clamp
    function automatic longint ref_entry(input int r, input int c);
        longint s = 0;
        for (int k = 0; k < 4; k++)
            s += longint'($signed(w_in[r][k])) * longint'($signed(w_in[c][k]));
`ifdef SYMM_GRAM_ROUND_EN
        s += 64'sd524288;
`endif
        s = s >>> 20;
        if (s > 64'sd33554431)       s = 64'sd33554431;
        else if (s < -64'sd33554432) s = -64'sd33554432;
        return s;
    endfunction

    function automatic gvec_t model();
        gvec_t v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(r*4+c)*26 +: 26] = 26'(ref_entry(r, c));
        return v;
    endfunction

    function automatic longint gval(input int r, input int c);
        return longint'($signed(g_o[r*4+c]));
    endfunction

    task automatic set_all(input longint v);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                w_in[r][k] = 26'(v);
    endtask

    task automatic start_run();
        @(negedge clk_gram);
        sb_q.push_back(model());
        en_gram = 1'b1;
        @(negedge clk_gram);
        en_gram = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_gram && n < 100) begin
            @(negedge clk_gram);
            n++;
        end
        check_eq({tag, "_done_seen"}, longint'(done_gram), 1);
        @(negedge clk_gram);
    endtask

    // Monitor: latency, busy length, accept stamps and scoreboard compare
    always @(negedge clk_gram) begin : mon
        gvec_t e;
        if (!rstn_gram) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy_gram) busy_cnt++;
            if (busy_gram && !prev_busy) acc_q.push_back(cyc);
            if (done_gram) begin
                done_cnt++;
                // done lands on the 41st busy cycle
                check_eq("done_latency", busy_cnt, 41);
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_done", longint'(done_gram), 0);
                end else begin
                    e = sb_q.pop_front();
                    for (int i = 0; i < 16; i++)
                        check_eq($sformatf("g%0d%0d", i/4 + 1, i%4 + 1),
                                 longint'($signed(g_o[i])),
                                 longint'($signed(e[i*26 +: 26])));
                end
            end
            if (!busy_gram && prev_busy) check_eq("busy_len", busy_cnt, 41);
            if (!busy_gram) busy_cnt = 0;
            prev_busy = busy_gram;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, guard, d0;
        rstn_gram = 1'b0;
        en_gram   = 1'b0;
        set_all(0);
        repeat (3) @(negedge clk_gram);
        check_eq("rst_busy", longint'(busy_gram), 0);
        check_eq("rst_done", longint'(done_gram), 0);
        for (int i = 0; i < 16; i++) check_eq($sformatf("rst_g%0d", i), longint'(g_o[i]), 0);
        #2 rstn_gram = 1'b1;

        // Identity
        set_all(0);
        for (int i = 0; i < 4; i++) w_in[i][i] = 26'd1048576;
        start_run();
        wait_done("ident");
        check_eq("ident_g11", gval(0, 0), 1048576);
        check_eq("ident_g44", gval(3, 3), 1048576);
        check_eq("ident_g23", gval(1, 2), 0);

        // All 0.5
        set_all(524288);
        start_run();
        wait_done("half");
        check_eq("half_g34", gval(2, 3), 1048576);

        // Continuous en: one accept per 42 cycles
        acc_q.delete();
        repeat (3) sb_q.push_back(model());
        @(negedge clk_gram);
        en_gram = 1'b1;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 300) begin
            @(negedge clk_gram);
            guard++;
            if (done_gram) n++;
        end
        en_gram = 1'b0;
        check_eq("cont_runs", n, 3);
        repeat (4) @(negedge clk_gram);
        check_eq("cont_idle", longint'(busy_gram), 0);
        check_eq("cont_accepts", acc_q.size(), 3);
        if (acc_q.size() >= 3) begin
            check_eq("cont_gap1", acc_q[1] - acc_q[0], 42);
            check_eq("cont_gap2", acc_q[2] - acc_q[1], 42);
        end

        // Sign and mirror
        set_all(0);
        w_in[0][0] = 26'(-1048576);
        w_in[1][0] = 26'd1048576;
        start_run();
        wait_done("sign");
        check_eq("sign_g12", gval(0, 1), -1048576);
        check_eq("sign_g21", gval(1, 0), -1048576);
        check_eq("sign_g22", gval(1, 1), 1048576);

        // Saturation, all positive
        set_all(33554431);
        start_run();
        wait_done("satp");
        check_eq("satp_g23", gval(1, 2), 33554431);

        // Saturation, row 1 negated
        for (int k = 0; k < 4; k++) w_in[0][k] = 26'(-33554432);
        start_run();
        wait_done("satn");
        check_eq("satn_g11", gval(0, 0), 33554431);
        check_eq("satn_g13", gval(0, 2), -33554432);
        check_eq("satn_g31", gval(2, 0), -33554432);

        // Rounding
        set_all(0);
        w_in[0][0] = 26'd512;
        w_in[0][1] = 26'd512;
        start_run();
        wait_done("rnd1");
        check_eq("rnd_g11", gval(0, 0), RND_G11);
        set_all(0);
        w_in[0][0] = 26'd512;
        w_in[1][0] = 26'(-512);
        start_run();
        wait_done("rnd2");
        check_eq("rnd_g12", gval(0, 1), RND_G12);

        // Random matrices, small and full range
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    w_in[r][k] = (t == 0) ? 26'($urandom_range(0, 4194303) - 2097152) : 26'($urandom);
            start_run();
            wait_done($sformatf("rand%0d", t));
        end

        // Reset mid-run aborts without done
        set_all(393216);
        d0 = done_cnt;
        start_run();
        repeat (19) @(negedge clk_gram);
        #2 rstn_gram = 1'b0;
        #1;
        check_eq("abort_busy", longint'(busy_gram), 0);
        check_eq("abort_done", longint'(done_gram), 0);
        for (int i = 0; i < 16; i++) check_eq($sformatf("abort_g%0d", i), longint'(g_o[i]), 0);
        sb_q.delete();
        repeat (2) @(negedge clk_gram);
        #2 rstn_gram = 1'b1;
        check_eq("abort_no_done", done_cnt, d0);

        // Run after abort
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                w_in[r][k] = 26'((r + 1) * 262144 - k * 131072);
        start_run();
        wait_done("post_abort");
        check_eq("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
